// File: rtl/sys1_hsram_arbiter.sv
// SEGA System 1 work-RAM arbiter between the Z80 bus and the hiscore engine.
// A hiscore request pauses the CPU, waits for the bus to go quiet, grants the
// RAM port to the hiscore engine, then hands it back after a settle period.
// Optional feature macro: SYS1_HSARB_STATS_EN adds grant/drop statistics ports.
module sys1_hsram_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int DRAIN_CYC   = 4,
  parameter int RELEASE_CYC = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          user_pause,
  output logic          pause,
  input  logic          cpu_busy,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_din,
  input  logic          hs_we,
  output logic          hs_grant,
  output logic [DW-1:0] hs_dout,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
`ifdef SYS1_HSARB_STATS_EN
  ,
  output logic [15:0]   grant_cnt,
  output logic [15:0]   drop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  localparam int CNT_MAX = (DRAIN_CYC > RELEASE_CYC) ? DRAIN_CYC : RELEASE_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD   = CW'(DRAIN_CYC - 1);
  localparam logic [CW-1:0] RELEASE_LOAD = CW'(RELEASE_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hs_grant_q, hs_grant_d;
  logic          pause_q, pause_d;
  logic [DW-1:0] hs_dout_q, hs_dout_d;

  // Next-state logic: drain the CPU bus, grant, then settle before handing back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_req) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!hs_req) begin
          state_d = ST_RELEASE;
          cnt_d   = RELEASE_LOAD;
        end else if (cpu_busy) begin
          cnt_d = DRAIN_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_GRANT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GRANT: begin
        if (!hs_req) begin
          state_d = ST_RELEASE;
          cnt_d   = RELEASE_LOAD;
        end
      end
      ST_RELEASE: begin
        if (hs_req) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    hs_grant_d = (state_d == ST_GRANT);
    pause_d    = (state_d == ST_IDLE) ? user_pause : 1'b1;
    hs_dout_d  = (state_q == ST_GRANT) ? ram_dout : hs_dout_q;
  end

  // State, counter and registered outputs; reset drops the grant at once.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hs_grant_q <= 1'b0;
      pause_q    <= 1'b0;
      hs_dout_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hs_grant_q <= hs_grant_d;
      pause_q    <= pause_d;
      hs_dout_q  <= hs_dout_d;
    end
  end

  // RAM port mux: hiscore owns it only in GRANT; DRAIN lets the in-flight write finish.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = 1'b0;
    case (state_q)
      ST_IDLE:    ram_we = cpu_we;
      ST_DRAIN:   ram_we = cpu_we & cpu_busy;
      ST_GRANT: begin
        ram_addr = hs_addr;
        ram_din  = hs_din;
        ram_we   = hs_we;
      end
      default:    ram_we = 1'b0;
    endcase
  end

  assign hs_grant = hs_grant_q;
  assign pause    = pause_q;
  assign hs_dout  = hs_dout_q;

`ifdef SYS1_HSARB_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating counters of grants issued and CPU writes blocked by the arbiter.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (state_q == ST_DRAIN && state_d == ST_GRANT && grant_cnt_q != 16'hFFFF)
      grant_cnt_d = grant_cnt_q + 16'd1;
    if (cpu_we && (state_q == ST_GRANT || state_q == ST_RELEASE) && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      grant_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sys1_hsram_arbiter.sv
// Directed self-checking bench for sys1_hsram_arbiter (default parameters).
module tb_sys1_hsram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        user_pause;
  logic        pause;
  logic        cpu_busy;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        hs_req;
  logic [15:0] hs_addr;
  logic [7:0]  hs_din;
  logic        hs_we;
  logic        hs_grant;
  logic [7:0]  hs_dout;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
`ifdef SYS1_HSARB_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] drop_cnt;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  sys1_hsram_arbiter dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .user_pause (user_pause),
    .pause      (pause),
    .cpu_busy   (cpu_busy),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_we     (cpu_we),
    .hs_req     (hs_req),
    .hs_addr    (hs_addr),
    .hs_din     (hs_din),
    .hs_we      (hs_we),
    .hs_grant   (hs_grant),
    .hs_dout    (hs_dout),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
`ifdef SYS1_HSARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  // 100 MHz-ish free-running clock.
  always #5 clk_sys = ~clk_sys;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the hiscore engine side of the arbiter.
  task automatic applyStimulus(input logic req, input logic [15:0] addr, input logic [7:0] din, input logic we);
    hs_req  = req;
    hs_addr = addr;
    hs_din  = din;
    hs_we   = we;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Directed sequence covering reset, grant, drain hold-off, readback, release, abort.
  initial begin
    reset      = 1'b1;
    user_pause = 1'b0;
    cpu_busy   = 1'b0;
    cpu_addr   = 16'h1234;
    cpu_din    = 8'h11;
    cpu_we     = 1'b0;
    ram_dout   = 8'h00;
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    #12;
    checkOutput("rst_pause", {31'd0, pause}, 32'd0);
    checkOutput("rst_grant", {31'd0, hs_grant}, 32'd0);
    checkOutput("rst_ram_we", {31'd0, ram_we}, 32'd0);
    checkOutput("rst_ram_addr", {16'd0, ram_addr}, 32'h1234);
    checkOutput("rst_hs_dout", {24'd0, hs_dout}, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] basic grant");
    applyStimulus(1'b1, 16'h0000, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("grant_wait_%0d", i), {31'd0, hs_grant}, {31'd0, (i == 5)});
      checkOutput($sformatf("pause_drain_%0d", i), {31'd0, pause}, 32'd1);
      if (i == 1) begin
        cpu_we = 1'b1;
        #1;
        checkOutput("drain_idle_we_blocked", {31'd0, ram_we}, 32'd0);
        cpu_we = 1'b0;
      end
    end
    applyStimulus(1'b1, 16'hC100, 8'h5A, 1'b1);
    #1;
    checkOutput("grant_ram_we", {31'd0, ram_we}, 32'd1);
    checkOutput("grant_ram_addr", {16'd0, ram_addr}, 32'hC100);
    checkOutput("grant_ram_din", {24'd0, ram_din}, 32'h5A);

    $display("[TB] readback latency");
    applyStimulus(1'b1, 16'hC200, 8'h00, 1'b0);
    ram_dout = 8'hA7;
    #1;
    checkOutput("hs_dout_before", {24'd0, hs_dout}, 32'h00);
    checkOutput("read_ram_addr", {16'd0, ram_addr}, 32'hC200);
    tick();
    checkOutput("hs_dout_after", {24'd0, hs_dout}, 32'hA7);

    $display("[TB] release");
    user_pause = 1'b1;
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    checkOutput("rel_grant_drop", {31'd0, hs_grant}, 32'd0);
    checkOutput("rel_pause_1", {31'd0, pause}, 32'd1);
    ram_dout = 8'h33;
    cpu_we   = 1'b1;
    #1;
    checkOutput("rel_ram_we_blocked", {31'd0, ram_we}, 32'd0);
    checkOutput("rel_ram_addr_cpu", {16'd0, ram_addr}, 32'h1234);
    tick();
    checkOutput("rel_pause_2", {31'd0, pause}, 32'd1);
    tick();
    checkOutput("idle_user_pause_hold", {31'd0, pause}, 32'd1);
    checkOutput("idle_ram_we_cpu", {31'd0, ram_we}, 32'd1);
    cpu_we     = 1'b0;
    user_pause = 1'b0;
    tick();
    checkOutput("idle_pause_follow", {31'd0, pause}, 32'd0);
    checkOutput("hs_dout_hold", {24'd0, hs_dout}, 32'hA7);

    $display("[TB] drain hold-off");
    applyStimulus(1'b1, 16'h0000, 8'h00, 1'b0);
    tick();
    cpu_busy = 1'b1;
    cpu_we   = 1'b1;
    #1;
    checkOutput("drain_inflight_we", {31'd0, ram_we}, 32'd1);
    tick();
    checkOutput("holdoff_grant_e2", {31'd0, hs_grant}, 32'd0);
    tick();
    checkOutput("holdoff_grant_e3", {31'd0, hs_grant}, 32'd0);
    cpu_busy = 1'b0;
    #1;
    checkOutput("drain_new_we_blocked", {31'd0, ram_we}, 32'd0);
    cpu_we = 1'b0;
    for (int i = 4; i <= 7; i++) begin
      tick();
      checkOutput($sformatf("holdoff_grant_e%0d", i), {31'd0, hs_grant}, {31'd0, (i == 7)});
    end

    $display("[TB] reset mid-grant");
    applyStimulus(1'b1, 16'hC300, 8'h77, 1'b1);
    #1;
    checkOutput("pre_reset_ram_addr", {16'd0, ram_addr}, 32'hC300);
    reset = 1'b1;
    #1;
    checkOutput("midrst_grant", {31'd0, hs_grant}, 32'd0);
    checkOutput("midrst_pause", {31'd0, pause}, 32'd0);
    checkOutput("midrst_ram_addr", {16'd0, ram_addr}, 32'h1234);
    checkOutput("midrst_ram_we", {31'd0, ram_we}, 32'd0);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] abort during drain");
    applyStimulus(1'b1, 16'h0000, 8'h00, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    checkOutput("abort_grant", {31'd0, hs_grant}, 32'd0);
    checkOutput("abort_pause_1", {31'd0, pause}, 32'd1);
    tick();
    checkOutput("abort_pause_2", {31'd0, pause}, 32'd1);
    tick();
    checkOutput("abort_pause_idle", {31'd0, pause}, 32'd0);
    checkOutput("abort_grant_idle", {31'd0, hs_grant}, 32'd0);

    $display("[TB] reassert during release");
    applyStimulus(1'b1, 16'h0000, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) tick();
    checkOutput("re_first_grant", {31'd0, hs_grant}, 32'd1);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    checkOutput("re_release_grant", {31'd0, hs_grant}, 32'd0);
    applyStimulus(1'b1, 16'h0000, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("re_pause_%0d", i), {31'd0, pause}, 32'd1);
      checkOutput($sformatf("re_grant_%0d", i), {31'd0, hs_grant}, {31'd0, (i == 5)});
    end
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    tick();
    tick();

    $display("[TB] grant loop with blocked cpu writes");
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b1, 16'h0000, 8'h00, 1'b0);
      for (int i = 1; i <= 5; i++) tick();
      checkOutput($sformatf("loop_grant_%0d", g), {31'd0, hs_grant}, 32'd1);
      for (int p = 0; p < ((g == 2) ? 2 : 1); p++) begin
        cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
      end
      applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
      tick();
      tick();
      tick();
      checkOutput($sformatf("loop_idle_pause_%0d", g), {31'd0, pause}, 32'd0);
    end
`ifdef SYS1_HSARB_STATS_EN
    checkOutput("stats_grant_cnt", {16'd0, grant_cnt}, 32'd3);
    checkOutput("stats_drop_cnt", {16'd0, drop_cnt}, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
